// File: rtl/rv32_ctrl_pkg.sv
// Shared types and opcode constants for the RV32I multi-cycle sequencer.
// Opcode values track the ALU's decode defines.
package rv32_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH,
        EXEC,
        MEM,
        WB,
        HALT
    } ctrl_state_t;

    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    function automatic logic is_mem_op(input logic [6:0] opcode);
        return (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    endfunction

endpackage

// File: rtl/rv32_multicycle_ctrl.sv
// Multi-cycle sequencer: owns PC/IR, arbitrates the single RAM port between
// fetch and load/store, and gates register writeback to one WB cycle.
module rv32_multicycle_ctrl
    import rv32_ctrl_pkg::*;
#(
    parameter int              DATA_WIDTH = 32,
    parameter int              RAM_WIDTH  = 31,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [RAM_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] pc_current,
    input  logic [DATA_WIDTH-1:0] alu_pc_next,
    input  logic [RAM_WIDTH-1:0]  alu_ram_address,
    input  logic [DATA_WIDTH-1:0] alu_store_data,
    output logic [DATA_WIDTH-1:0] alu_load_data,
    input  logic                  alu_rf_we,
    output logic                  rf_we,
    output logic                  retire,
    output logic                  halted
);

    ctrl_state_t           state;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr_q;
    logic [DATA_WIDTH-1:0] load_q;
    logic [6:0]            opcode;

    assign opcode        = instr_q[6:0];
    assign instr         = instr_q;
    assign pc_current    = pc;
    assign alu_load_data = load_q;

    // Stores and branches never write rd, whatever the ALU requests.
    assign rf_we = (state == WB) && alu_rf_we &&
                   (opcode != OPC_STORE) && (opcode != OPC_BRANCH);

    // Request/address/data are registered on entry to FETCH/MEM so they hold
    // steady for the whole handshake regardless of ALU input activity.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            instr_q <= NOP_INSTR;
            load_q  <= '0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            retire  <= 1'b0;
            halted  <= 1'b0;
        end else begin
            retire <= 1'b0;
            case (state)
                FETCH: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc[RAM_WIDTH-1:0];
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        instr_q <= mem_rdata;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (is_mem_op(opcode)) begin
                        mem_req   <= 1'b1;
                        mem_we    <= (opcode == OPC_STORE);
                        mem_addr  <= alu_ram_address;
                        mem_wdata <= alu_store_data;
                        state     <= MEM;
                    end else begin
                        retire <= 1'b1;
                        state  <= WB;
                    end
                end
                MEM: begin
                    if (mem_req && mem_ack) begin
                        if (!mem_we) begin
                            load_q <= mem_rdata;
                        end
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        retire  <= 1'b1;
                        state   <= WB;
                    end
                end
                WB: begin
                    if (alu_pc_next[1:0] != 2'b00) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else begin
                        // Launch the next fetch straight away; no idle FETCH cycle.
                        pc       <= alu_pc_next;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= alu_pc_next[RAM_WIDTH-1:0];
                        state    <= FETCH;
                    end
                end
                HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// Directed bench for rv32_multicycle_ctrl: the bench plays RAM and ALU by hand.
module tb_rv32_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req, mem_we;
    logic [30:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack;
    logic [31:0] instr, pc_current, alu_pc_next, alu_store_data, alu_load_data;
    logic [30:0] alu_ram_address;
    logic        alu_rf_we, rf_we, retire, halted;

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;
    int start_c;

    localparam logic [31:0] ADDI_W = 32'h0050_0093;  // addi x1,x0,5
    localparam logic [31:0] LW_W   = 32'h0080_2103;  // lw   x2,8(x0)
    localparam logic [31:0] SW_W   = 32'h0050_2823;  // sw   x5,16(x0)
    localparam logic [31:0] BEQ_W  = 32'h0000_0063;  // beq  x0,x0,0

    rv32_multicycle_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .instr          (instr),
        .pc_current     (pc_current),
        .alu_pc_next    (alu_pc_next),
        .alu_ram_address(alu_ram_address),
        .alu_store_data (alu_store_data),
        .alu_load_data  (alu_load_data),
        .alu_rf_we      (alu_rf_we),
        .rf_we          (rf_we),
        .retire         (retire),
        .halted         (halted)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Called at a negedge where a fetch request is expected; acks after `waits` idle cycles.
    task automatic fetch(input logic [31:0] word, input logic [30:0] addr, input int waits);
        check("fetch_req", 32'(mem_req), 32'd1);
        check("fetch_we", 32'(mem_we), 32'd0);
        check("fetch_addr", 32'(mem_addr), 32'(addr));
        for (int i = 0; i < waits; i++) begin
            cyc();
            check("fetch_req_hold", 32'(mem_req), 32'd1);
            check("fetch_addr_hold", 32'(mem_addr), 32'(addr));
        end
        mem_ack   = 1'b1;
        mem_rdata = word;
        cyc();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        check("exec_instr", instr, word);
        check("exec_req", 32'(mem_req), 32'd0);
        check("exec_rf_we", 32'(rf_we), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        alu_pc_next = '0; alu_ram_address = '0; alu_store_data = '0; alu_rf_we = 1'b0;
        cyc(); cyc();
        // Reset state
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_retire", 32'(retire), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_pc", pc_current, 32'h0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_load", alu_load_data, 32'h0);
        rst_n = 1'b1;
        cyc();

        // 1: ADDI, zero-wait
        start_c = cycle;
        alu_rf_we = 1'b1; alu_pc_next = 32'h4;
        fetch(ADDI_W, 31'h0, 0);
        check("t1_exec_retire", 32'(retire), 32'd0);
        cyc();
        check("t1_wb_retire", 32'(retire), 32'd1);
        check("t1_wb_rf_we", 32'(rf_we), 32'd1);
        check("t1_latency", 32'(cycle - start_c + 1), 32'd3);
        cyc();
        check("t1_pc", pc_current, 32'h4);
        check("t1_retire_low", 32'(retire), 32'd0);
        check("t1_rf_we_low", 32'(rf_we), 32'd0);

        // 2: LW with 3 wait cycles on the data access
        start_c = cycle;
        fetch(LW_W, 31'h4, 0);
        alu_ram_address = 31'h8; alu_rf_we = 1'b1; alu_pc_next = 32'h8;
        cyc();
        for (int i = 0; i < 3; i++) begin
            check("t2_req", 32'(mem_req), 32'd1);
            check("t2_we", 32'(mem_we), 32'd0);
            check("t2_addr", 32'(mem_addr), 32'h8);
            check("t2_rf_we_mem", 32'(rf_we), 32'd0);
            cyc();
        end
        check("t2_req_last", 32'(mem_req), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        cyc();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        check("t2_load", alu_load_data, 32'hDEAD_BEEF);
        check("t2_rf_we", 32'(rf_we), 32'd1);
        check("t2_retire", 32'(retire), 32'd1);
        check("t2_wb_req", 32'(mem_req), 32'd0);
        check("t2_latency", 32'(cycle - start_c + 1), 32'd7);
        cyc();
        check("t2_pc", pc_current, 32'h8);

        // 3: SW, one wait cycle, ALU inputs disturbed mid-handshake
        fetch(SW_W, 31'h8, 1);
        alu_ram_address = 31'h10; alu_store_data = 32'h1234_5678;
        alu_rf_we = 1'b1; alu_pc_next = 32'hC;
        cyc();
        alu_ram_address = 31'h0; alu_store_data = 32'h0;
        check("t3_we", 32'(mem_we), 32'd1);
        check("t3_wdata", mem_wdata, 32'h1234_5678);
        check("t3_addr", 32'(mem_addr), 32'h10);
        cyc();
        check("t3_we_hold", 32'(mem_we), 32'd1);
        check("t3_wdata_hold", mem_wdata, 32'h1234_5678);
        check("t3_addr_hold", 32'(mem_addr), 32'h10);
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        check("t3_rf_we", 32'(rf_we), 32'd0);
        check("t3_retire", 32'(retire), 32'd1);
        check("t3_load_kept", alu_load_data, 32'hDEAD_BEEF);
        cyc();
        check("t3_pc", pc_current, 32'hC);

        // 4: branch with raw write request set
        fetch(BEQ_W, 31'hC, 0);
        alu_rf_we = 1'b1; alu_pc_next = 32'h40;
        cyc();
        check("t4_rf_we", 32'(rf_we), 32'd0);
        check("t4_retire", 32'(retire), 32'd1);
        cyc();
        check("t4_pc", pc_current, 32'h40);
        check("t4_addr", 32'(mem_addr), 32'h40);

        // 5: misaligned next PC traps
        fetch(ADDI_W, 31'h40, 0);
        alu_rf_we = 1'b1; alu_pc_next = 32'h42;
        cyc();
        check("t5_rf_we", 32'(rf_we), 32'd1);
        check("t5_retire", 32'(retire), 32'd1);
        cyc();
        check("t5_halted", 32'(halted), 32'd1);
        check("t5_pc", pc_current, 32'h40);
        check("t5_retire_low", 32'(retire), 32'd0);
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t5_req_halt", 32'(mem_req), 32'd0);
            check("t5_halt_sticky", 32'(halted), 32'd1);
            check("t5_rf_we_halt", 32'(rf_we), 32'd0);
        end
        mem_ack = 1'b0;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check("t5_rst_halted", 32'(halted), 32'd0);
        check("t5_rst_pc", pc_current, 32'h0);
        check("t5_rst_req", 32'(mem_req), 32'd0);
        cyc();

        // 6: spurious ack in EXEC, then reset during a MEM wait
        fetch(LW_W, 31'h0, 0);
        alu_ram_address = 31'h8; alu_rf_we = 1'b1; alu_pc_next = 32'h4;
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        cyc();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        check("t6_instr_kept", instr, LW_W);
        check("t6_load_kept", alu_load_data, 32'h0);
        check("t6_mem_req", 32'(mem_req), 32'd1);
        check("t6_mem_addr", 32'(mem_addr), 32'h8);
        cyc();
        check("t6_still_waiting", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check("t6_rst_req", 32'(mem_req), 32'd0);
        check("t6_rst_pc", pc_current, 32'h0);
        check("t6_rst_instr", instr, 32'h0000_0013);
        check("t6_rst_retire", 32'(retire), 32'd0);
        cyc();
        check("t6_refetch_req", 32'(mem_req), 32'd1);
        check("t6_refetch_addr", 32'(mem_addr), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
